// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three ports around the arbiter: the instruction-fetch
//   requester (i_*), the data requester (d_*) and the shared memory port (m_*).
//   modport slave  : the arbiter's view (requests in, grants/responses out,
//                    drives the shared memory port, receives m_rdata/m_ready).
//   modport master : the environment's view (requesters plus memory model).
interface mem_port_arbiter_if;
  // instruction fetch port
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [31:0] i_rdata;
  // data port
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [63:0] d_rdata;
  // shared memory port
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
           m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 64-bit memory port between an instruction-fetch requester and
//   a data requester. One transaction is outstanding at a time. Data requests
//   win ties, except when the fetch side has watched STARVE_LIMIT consecutive
//   data grants while waiting; then the fetch wins.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data and shared memory ports)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // 1..15
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  starve_reg, starve_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;

  logic        i_valid_reg, d_valid_reg;
  logic [31:0] i_rdata_reg;
  logic [63:0] d_rdata_reg;

  logic        i_gnt, d_gnt;
  logic        starved;

  // 32-bit lanes of the returned memory word; a fetch picks one by addr bit 2.
  logic [31:0] fetch_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign fetch_lane[gi] = bus.m_rdata[gi*32 +: 32];
    end
  endgenerate

  // Next-state, arbitration and latch updates.
  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    addr_next   = addr_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    starved     = (starve_reg == LIMIT);

    case (state_reg)
      IDLE: begin
        // Grants are suppressed while reset is held so nothing is accepted
        // into a transaction that the reset edge would discard anyway.
        if (!rst) begin
          if (bus.i_req && (!bus.d_req || starved)) begin
            i_gnt = 1'b1;
          end else if (bus.d_req) begin
            d_gnt = 1'b1;
          end
        end

        if (i_gnt) begin
          state_next  = SERVE_I;
          addr_next   = bus.i_addr;
          we_next     = 1'b0;
          wdata_next  = '0;
          starve_next = '0;
        end else if (d_gnt) begin
          state_next = SERVE_D;
          addr_next  = bus.d_addr;
          we_next    = bus.d_we;
          wdata_next = bus.d_wdata;
          // Only data grants that overtake a waiting fetch count as starvation.
          if (bus.i_req && (starve_reg < LIMIT)) begin
            starve_next = starve_reg + 4'd1;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        if (bus.m_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      starve_reg  <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      i_valid_reg <= 1'b0;
      d_valid_reg <= 1'b0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      starve_reg  <= starve_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      wdata_reg   <= wdata_next;
      i_valid_reg <= (state_reg == SERVE_I) && bus.m_ready;
      d_valid_reg <= (state_reg == SERVE_D) && bus.m_ready;
      if ((state_reg == SERVE_I) && bus.m_ready) begin
        i_rdata_reg <= fetch_lane[addr_reg[2]];
      end
      // Store completions leave the last load data in place.
      if ((state_reg == SERVE_D) && bus.m_ready && !we_reg) begin
        d_rdata_reg <= bus.m_rdata;
      end
    end
  end

  // Control outputs are forced low during reset, even in the cycle where
  // the state register still shows an abandoned transaction.
  assign bus.i_gnt   = i_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.i_valid = i_valid_reg && !rst;
  assign bus.d_valid = d_valid_reg && !rst;
  assign bus.i_rdata = i_rdata_reg;
  assign bus.d_rdata = d_rdata_reg;
  assign bus.m_req   = (state_reg != IDLE) && !rst;
  assign bus.m_we    = (state_reg == SERVE_D) && we_reg && !rst;
  assign bus.m_addr  = addr_reg;
  assign bus.m_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized traffic. Requesters push the
//   expected response data into per-port queues when they issue; a monitor
//   process running on the falling edge pops and compares on every VALID and
//   also tracks a transaction-level model of grants, memory-port activity and
//   VALID timing, driven only by the bench's own inputs.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: 16 words addressed by addr[6:3]. Fetches use addr[6]=0,
  // random data traffic uses addr[6]=1.
  logic [63:0] mem [16];
  assign bus.m_rdata = mem[bus.m_addr[6:3]];

  int          passed = 0;
  int          total  = 0;
  int          ready_pct = 100;
  logic [63:0] last_load = '0;
  logic [63:0] iq [$];
  logic [63:0] dq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory readiness: random per cycle with probability ready_pct %.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic wait_gnt(input bit is_d);
    bit seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? bus.d_gnt : bus.i_gnt;
    end
    if (!seen) begin
      total++;
      $display("FAIL %s_grant_timeout: got no grant, required a grant within 500 cycles", is_d ? "d" : "i");
    end
  endtask

  task automatic wait_valid(input bit is_d);
    bit seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? bus.d_valid : bus.i_valid;
    end
    if (!seen) begin
      total++;
      $display("FAIL %s_valid_timeout: got no valid, required a valid within 500 cycles", is_d ? "d" : "i");
    end
  endtask

  task automatic i_issue(input logic [63:0] a);
    logic [63:0] w;
    @(posedge clk); #1;
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    w = mem[a[6:3]];
    iq.push_back(a[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]});
    wait_gnt(1'b0);
  endtask

  task automatic i_drop();
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic d_issue(input logic we, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] e;
    @(posedge clk); #1;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    if (we) begin
      e = last_load;
    end else begin
      e = mem[a[6:3]];
      last_load = e;
    end
    dq.push_back(e);
    wait_gnt(1'b1);
  endtask

  task automatic d_drop();
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  // Monitor: transaction-level model plus scoreboard.
  initial begin : monitor
    int          phase;   // 0 idle, 1 fetch in flight, 2 data in flight
    int          pend;    // which port owes a VALID this cycle
    int          starve;
    logic [63:0] lat_addr, lat_wdata;
    logic        lat_we;
    logic        eg_i, eg_d, ev_i, ev_d, em_req, em_we;

    for (int k = 0; k < 16; k++) mem[k] = {$urandom, $urandom};
    mem[0] = 64'hAAAA_BBBB_1111_2222;
    phase = 0; pend = 0; starve = 0;
    lat_addr = '0; lat_wdata = '0; lat_we = 1'b0;

    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl", {58'h0, bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.m_req, bus.m_we}, 64'h0);
        phase = 0; pend = 0; starve = 0;
        iq.delete();
        dq.delete();
      end else begin
        eg_i = 1'b0; eg_d = 1'b0;
        ev_i = (pend == 1);
        ev_d = (pend == 2);
        pend = 0;
        em_req = 1'b0; em_we = 1'b0;
        if (phase == 0) begin
          if (bus.i_req && (!bus.d_req || starve == LIMIT)) eg_i = 1'b1;
          else if (bus.d_req) eg_d = 1'b1;
        end else begin
          em_req = 1'b1;
          em_we  = lat_we;
        end

        chk("ctrl_gnt_valid_mreq_mwe",
            {58'h0, bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.m_req, bus.m_we},
            {58'h0, eg_i, eg_d, ev_i, ev_d, em_req, em_we});
        if (phase != 0) begin
          chk("m_addr", bus.m_addr, lat_addr);
          if (lat_we) chk("m_wdata", bus.m_wdata, lat_wdata);
        end

        if (bus.i_valid) begin
          if (iq.size() == 0) begin
            total++;
            $display("FAIL i_unexpected_valid: got i_valid, required none (no fetch outstanding)");
          end else begin
            logic [63:0] e;
            e = iq.pop_front();
            chk("i_rdata", {32'h0, bus.i_rdata}, e);
            $display("fetch complete  i_rdata=%h expected=%h", bus.i_rdata, e[31:0]);
          end
        end
        if (bus.d_valid) begin
          if (dq.size() == 0) begin
            total++;
            $display("FAIL d_unexpected_valid: got d_valid, required none (no data access outstanding)");
          end else begin
            logic [63:0] e;
            e = dq.pop_front();
            chk("d_rdata", bus.d_rdata, e);
            $display("data complete   d_rdata=%h expected=%h", bus.d_rdata, e);
          end
        end

        if (phase != 0 && bus.m_ready) begin
          pend = phase;
          if (lat_we) mem[lat_addr[6:3]] = lat_wdata;
          phase = 0;
        end else if (eg_i) begin
          phase = 1; lat_addr = bus.i_addr; lat_we = 1'b0; lat_wdata = '0;
          starve = 0;
        end else if (eg_d) begin
          phase = 2; lat_addr = bus.d_addr; lat_we = bus.d_we; lat_wdata = bus.d_wdata;
          if (bus.i_req && starve < LIMIT) starve++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_i_rdata", {32'h0, bus.i_rdata}, 64'h0);
    chk("reset_d_rdata", bus.d_rdata, 64'h0);

    // Single fetch from 0x4: upper half of the word.
    i_issue(64'h4);
    i_drop();
    wait_valid(1'b0);

    // Simultaneous fetch and load: data first, fetch right behind.
    fork
      begin i_issue(64'h4);  i_drop(); end
      begin d_issue(1'b0, 64'h10, 64'h0); d_drop(); end
    join
    repeat (6) @(negedge clk);

    // Held data stream against a waiting fetch: LIMIT data grants, then fetch.
    fork
      begin
        for (int k = 0; k < 7; k++) d_issue(1'b0, 64'h40 + 64'(k * 8), 64'h0);
        d_drop();
      end
      begin i_issue(64'h8); i_drop(); end
    join
    repeat (8) @(negedge clk);

    // Store with a slow memory: port must hold steady while waiting.
    ready_pct = 0;
    repeat (2) @(posedge clk);
    d_issue(1'b1, 64'h18, 64'h1234);
    d_drop();
    repeat (3) @(negedge clk);
    ready_pct = 100;
    wait_valid(1'b1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a data access.
    ready_pct = 0;
    repeat (2) @(posedge clk);
    d_issue(1'b0, 64'h48, 64'h0);
    d_drop();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_load = '0;
    @(negedge clk);
    chk("post_rst_d_rdata", bus.d_rdata, 64'h0);
    chk("post_rst_i_rdata", {32'h0, bus.i_rdata}, 64'h0);
    ready_pct = 100;
    d_issue(1'b0, 64'h48, 64'h0);
    d_drop();
    wait_valid(1'b1);

    // Randomized traffic with a jittery memory.
    ready_pct = 60;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [63:0] a;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = {$urandom, $urandom} & ~64'h40;
          i_issue(a);
          i_drop();
          wait_valid(1'b0);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          logic [63:0] a;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = {$urandom, $urandom} | 64'h40;
          d_issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
          d_drop();
          wait_valid(1'b1);
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
